// File: rtl/read_controller.sv
// Frame readback engine: walks the frame BRAM in ascending address order and
// streams every 24-bit pixel to the UART transmitter as three bytes, MSB first.
module read_controller #(
    parameter int LAST_ADDR = 196607,
    parameter int ADDR_W    = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    input  logic [23:0]       dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        byte_idx
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t      state;
    state_t      state_nxt;
    logic [23:0] pixel;
    logic        accept;

    assign accept = (state == SEND) && tx_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        en        = 1'b0;
        tx_valid  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ: begin
                en        = 1'b1;
                state_nxt = LATCH;
            end
            LATCH:   state_nxt = SEND;
            SEND: begin
                tx_valid = 1'b1;
                if (accept && byte_idx == 2'd2)
                    state_nxt = (addr == LAST) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx_data is registered so it only moves in LATCH or on an accepted byte;
    // the byte_idx clear in DONE therefore never disturbs the output byte.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            byte_idx <= 2'd0;
            pixel    <= 24'h0;
            tx_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                LATCH: begin
                    pixel    <= dout;
                    tx_data  <= dout[23:16];
                    byte_idx <= 2'd0;
                end
                SEND: begin
                    if (accept) begin
                        case (byte_idx)
                            2'd0: begin
                                tx_data  <= pixel[15:8];
                                byte_idx <= 2'd1;
                            end
                            2'd1: begin
                                tx_data  <= pixel[7:0];
                                byte_idx <= 2'd2;
                            end
                            default: if (addr != LAST) addr <= addr + 1'b1;
                        endcase
                    end
                end
                DONE: begin
                    addr     <= '0;
                    byte_idx <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_read_controller.sv
// Directed bench for read_controller: dut_a holds a one-pixel frame, dut_b a
// four-pixel frame; each has its own 1-cycle-latency BRAM model.
module tb_read_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a, start_b, ready_a, ready_b;
    logic        en_a, en_b_s, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [17:0] addr_a, addr_b;
    logic [23:0] dout_a, dout_b;
    logic [7:0]  data_a, data_b;
    logic [1:0]  idx_a, idx_b;

    logic [23:0] mem_a [4];
    logic [23:0] mem_b [4];

    read_controller #(.LAST_ADDR(0), .ADDR_W(18)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .en(en_a), .addr(addr_a),
        .dout(dout_a), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
        .busy(busy_a), .done(done_a), .byte_idx(idx_a)
    );

    read_controller #(.LAST_ADDR(3), .ADDR_W(18)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .en(en_b_s), .addr(addr_b),
        .dout(dout_b), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
        .busy(busy_b), .done(done_b), .byte_idx(idx_b)
    );

    always @(posedge clk) begin
        if (en_a) dout_a <= mem_a[addr_a[1:0]];
        if (en_b_s) dout_b <= mem_b[addr_b[1:0]];
    end

    // Transfer / read-enable / done monitors
    logic [7:0]  bytes_a [$];
    logic [7:0]  bytes_b [$];
    logic [17:0] reads_b [$];
    int          dones_b = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (valid_a && ready_a) bytes_a.push_back(data_a);
            if (valid_b && ready_b) bytes_b.push_back(data_b);
            if (en_b_s) reads_b.push_back(addr_b);
            if (done_b) dones_b++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] frame_bytes [12];
    logic [7:0] bp_bytes [3];

    initial begin
        frame_bytes = '{8'h01, 8'h02, 8'h03, 8'h02, 8'h04, 8'h06,
                        8'h03, 8'h06, 8'h09, 8'h04, 8'h08, 8'h0C};
        bp_bytes    = '{8'h12, 8'h34, 8'h56};
        mem_a = '{24'hA1B2C3, 24'h0, 24'h0, 24'h0};
        mem_b = '{24'h010203, 24'h020406, 24'h030609, 24'h04080C};

        // Reset for two cycles with start asserted: start must be ignored
        rst = 1'b1; start_a = 1'b1; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        repeat (2) tick();
        check("rst_en", en_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 8'h00);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_idx", idx_a, 0);
        rst = 1'b0; start_a = 1'b0;
        tick();
        check("rst_start_ignored", busy_a, 0);

        // Single pixel, tx_ready high: exact cycle-by-cycle timing
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();                                    // T+1
        start_a = 1'b0;
        check("sp_t1_busy", busy_a, 1);
        check("sp_t1_en", en_a, 1);
        check("sp_t1_addr", addr_a, 0);
        check("sp_t1_valid", valid_a, 0);
        tick();                                    // T+2
        check("sp_t2_en", en_a, 0);
        check("sp_t2_valid", valid_a, 0);
        tick();                                    // T+3
        check("sp_t3_valid", valid_a, 1);
        check("sp_t3_data", data_a, 8'hA1);
        check("sp_t3_idx", idx_a, 0);
        tick();                                    // T+4
        check("sp_t4_data", data_a, 8'hB2);
        check("sp_t4_idx", idx_a, 1);
        tick();                                    // T+5
        check("sp_t5_data", data_a, 8'hC3);
        check("sp_t5_idx", idx_a, 2);
        tick();                                    // T+6
        check("sp_t6_done", done_a, 1);
        check("sp_t6_valid", valid_a, 0);
        check("sp_t6_busy", busy_a, 1);
        tick();                                    // T+7
        check("sp_t7_busy", busy_a, 0);
        check("sp_t7_done", done_a, 0);
        check("sp_t7_addr", addr_a, 0);
        check("sp_bytes", bytes_a.size(), 3);

        // Backpressure: four stalled cycles per byte before acceptance
        bytes_a.delete();
        mem_a[0] = 24'h123456;
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (2) tick();                         // now SEND, byte 0
        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 4; s++) begin
                check("bp_stall_valid", valid_a, 1);
                check("bp_stall_data", data_a, bp_bytes[k]);
                tick();
            end
            check("bp_accept_data", data_a, bp_bytes[k]);
            ready_a = 1'b1;
            tick();
            ready_a = 1'b0;
        end
        check("bp_done", done_a, 1);
        tick();
        check("bp_count", bytes_a.size(), 3);
        for (int k = 0; k < 3; k++) check("bp_byte", bytes_a[k], bp_bytes[k]);

        // Four-pixel frame with a start pulse mid-frame
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (7) tick();
        check("fr_midframe_busy", busy_b, 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 60 && !done_b; i++) tick();
        check("fr_done_seen", done_b, 1);
        tick();
        check("fr_idle_busy", busy_b, 0);
        repeat (4) tick();
        check("fr_no_restart", busy_b, 0);
        check("fr_byte_count", bytes_b.size(), 12);
        for (int k = 0; k < 12 && k < bytes_b.size(); k++)
            check("fr_byte", bytes_b[k], frame_bytes[k]);
        check("fr_read_count", reads_b.size(), 4);
        for (int k = 0; k < 4 && k < reads_b.size(); k++)
            check("fr_read_addr", reads_b[k], k);
        check("fr_done_count", dones_b, 1);

        // Reset mid-frame while offering byte 1 with tx_ready high
        bytes_b.delete();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (3) tick();                         // byte 0 accepted at previous edge
        check("mr_idx", idx_b, 1);
        check("mr_valid", valid_b, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid_after", valid_b, 0);
        check("mr_addr_after", addr_b, 0);
        check("mr_busy_after", busy_b, 0);
        check("mr_idx_after", idx_b, 0);
        check("mr_data_after", data_b, 8'h00);
        check("mr_bytes_sent", bytes_b.size(), 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("mr_restart_en", en_b_s, 1);
        check("mr_restart_addr", addr_b, 0);
        repeat (2) tick();
        check("mr_restart_data", data_b, 8'h01);
        check("mr_restart_idx", idx_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/read_controller.md
# read_controller

Image readback engine: on a start pulse, reads every stored 24-bit pixel from the frame BRAM in ascending address order and streams each as three bytes to the UART transmitter. It is the counterpart of the byte-receive/pixel-write path: bytes emerge in the same order they were originally received, so a full write followed by a full readback round-trips the image unchanged. Sits between the frame BRAM read port and the UART TX byte interface.

## Interface
- `LAST_ADDR`, 196607: final pixel address; a frame is `LAST_ADDR+1` words.
- `ADDR_W`, 18: BRAM address width.

- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to read back one full frame; honoured only in IDLE.
- `en` out 1: BRAM read enable.
- `addr` out ADDR_W: BRAM read address.
- `dout` in 24: BRAM read data, valid exactly one cycle after the cycle in which `en`=1.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` is valid; held until accepted.
- `tx_ready` in 1: transmitter can accept; transfer occurs in the cycle where `tx_valid && tx_ready`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after the last byte of the frame is accepted.
- `byte_idx` out 2: index of the byte currently offered (0,1,2), for debug.

## Operation
- States: IDLE, READ, LATCH, SEND, DONE.
- IDLE: `addr`=0. On `start`=1 -> READ. Otherwise stay.
- READ: `en`=1 for exactly one cycle, `addr` = current pixel address -> LATCH.
- LATCH: capture `dout` into a 24-bit pixel register; `byte_idx`<=0 -> SEND.
- SEND: `tx_valid`=1, `tx_data` = pixel[23:16], [15:8], [7:0] for `byte_idx` 0, 1, 2. On acceptance with `byte_idx`<2: `byte_idx`+1, stay in SEND. On acceptance with `byte_idx`=2:
  - If `addr`=`LAST_ADDR` -> DONE.
  - Otherwise `addr`+1 -> READ.
- DONE: `done`=1 for one cycle; `addr`<=0, `byte_idx`<=0 -> IDLE.
- `start` received outside IDLE is ignored; it is not queued.
- `tx_data` changes only on acceptance or in LATCH; it is stable while `tx_valid`=1 and `tx_ready`=0.
- `addr` increments only as stated above; no wrap past `LAST_ADDR`.
- `tx_ready` is ignored when `tx_valid`=0.

## Timing
- Reset values: state IDLE, `en` 0, `addr` 0, `tx_valid` 0, `tx_data` 0x00, `busy` 0, `done` 0, `byte_idx` 0, pixel register 0.
- Reset mid-frame, including in SEND with `tx_valid`=1, aborts immediately. The next cycle shows all reset values; no partial byte is completed.
- Start to first `tx_valid`: `start` sampled in cycle T, READ in T+1, LATCH in T+2, SEND (`tx_valid`=1) in T+3.
- Per pixel, with `tx_ready` tied high: READ, LATCH, then three SEND cycles = 5 cycles per pixel. Next READ follows the cycle of the third acceptance.
- Last pixel: the third acceptance is in cycle A; DONE (`done`=1) in A+1; IDLE with `busy`=0 in A+2. A `start` in A+2 begins a new frame.
- `busy` is registered with the state: it rises the cycle after `start` and falls in the cycle state returns to IDLE.
- `en` is never high outside READ. BRAM read latency is fixed at 1 cycle.

## Test plan
- Reset check: assert `rst` for 2 cycles -> all outputs at their reset values; `start` during `rst` is ignored.
- Single pixel with `LAST_ADDR`=0 and BRAM[0]=0xA1B2C3, `tx_ready`=1 -> bytes 0xA1, 0xB2, 0xC3 on consecutive cycles T+3..T+5; `done` at T+6; `busy` low at T+7.
- Backpressure, BRAM[0]=0x123456: hold `tx_ready`=0 for 4 cycles in each byte -> `tx_data` stable at 0x12, then 0x34, then 0x56 while stalled; exactly 3 transfers occur.
- Frame order with `LAST_ADDR`=3, BRAM[i]=0x010203*(i+1) -> 12 bytes in ascending address order, MSB first; `en` pulses at addresses 0,1,2,3 only; one `done` pulse.
- Start while busy: pulse `start` mid-frame -> no restart; byte count still 3*(`LAST_ADDR`+1).
- Reset mid-frame at `byte_idx`=1 -> next cycle IDLE, `tx_valid`=0, `addr`=0. A new `start` then sends from address 0, byte 0.
